// File: rtl/jtgng_ram_rr.sv
// Three-way round-robin picker for jtgng_ram_arb.
// The pointer names the requester that has top priority this cycle. It moves
// to the index after the winner whenever a grant is issued.
module jtgng_ram_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;

    // Grant the first requester found when scanning upward from the pointer.
    // Pointer value 3 never occurs and is treated as 0.
    always_comb begin
        gnt = 3'b000;
        if (en) begin
            case (ptr_q)
                2'd1: begin
                    if      (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if      (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if      (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    // Next priority is the index just after the winner.
    always_comb begin
        ptr_d = 2'd0;
        if (gnt[0]) ptr_d = 2'd1;
        if (gnt[1]) ptr_d = 2'd2;
    end

    // Pointer register, updated only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else if (|gnt) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/jtgng_ram_arb.sv
// Single-port RAM arbiter for three requesters.
// After reset the RAM can be swept to CLR_VAL. Then grants are issued
// round-robin: a grant in cycle T drives the RAM port in T+1. A granted read
// gets its data strobe in T+2, when the RAM's registered output is valid.
module jtgng_ram_arb #(
    parameter int unsigned    DW      = 8,
    parameter int unsigned    AW      = 10,
    parameter bit             CLR_EN  = 1'b1,
    parameter logic [DW-1:0]  CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] din,
    output logic [2:0]    ack,
    output logic [DW-1:0] dout,
    output logic [2:0]    dout_ok,
    output logic          clr_busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_q
);

    typedef enum logic {
        StClear = 1'b0,
        StArb   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LastAddr = {AW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic          in_clear;
    logic          arb_en;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;
    logic          sel_we;

    // Access pipeline: stage 1 drives the RAM, stage 2 flags valid read data.
    logic          en_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [2:0]    rd_q;
    logic [2:0]    ok_q;

    // Reset is folded in combinationally so outputs are quiet for every cycle
    // rst is high, including the first one.
    assign in_clear = (state_q == StClear) && !rst;
    assign arb_en   = (state_q == StArb) && !rst;

    jtgng_ram_rr u_rr (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req),
        .gnt (ack)
    );

    // Sweep counter and CLEAR -> ARB transition. The counter stops on the last address.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                if (clr_cnt_q == LastAddr) begin
                    state_d = StArb;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLR_EN ? StClear : StArb;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Select the winner's address, data and write enable (ack is one-hot).
    always_comb begin
        sel_addr = addr[AW-1:0];
        sel_din  = din[DW-1:0];
        sel_we   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ack[i]) begin
                sel_addr = addr[i*AW +: AW];
                sel_din  = din[i*DW +: DW];
                sel_we   = we[i];
            end
        end
    end

    // Capture the winner for the RAM cycle and track reads to their data strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            rd_q   <= 3'b000;
            ok_q   <= 3'b000;
        end else begin
            en_q <= |ack;
            we_q <= (|ack) && sel_we;
            if (|ack) begin
                addr_q <= sel_addr;
                din_q  <= sel_din;
            end
            rd_q <= ack & ~we;
            ok_q <= rd_q;
        end
    end

    // RAM port: the sweep owns it during CLEAR, the pipeline afterwards.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (in_clear) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
            ram_din  = CLR_VAL;
        end else if (!rst) begin
            ram_en   = en_q;
            ram_we   = en_q && we_q;
            ram_addr = addr_q;
            ram_din  = din_q;
        end
    end

    // Status and read-data outputs.
    always_comb begin
        dout     = ram_q;
        dout_ok  = rst ? 3'b000 : ok_q;
        clr_busy = rst ? CLR_EN : (state_q == StClear);
    end

endmodule

// File: tb/tb_jtgng_ram_arb.sv
// Self-checking bench for jtgng_ram_arb (DW=8, AW=4).
// u_dut sweeps after reset and feeds a behavioural RAM. u_dut_b has the sweep
// disabled and only checks that a grant can happen in the first cycle.
module tb_jtgng_ram_arb;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] din;
    logic [2:0]    ack, dout_ok;
    logic [DW-1:0] dout;
    logic          clr_busy, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_q;

    logic [2:0]    req_b;
    logic [2:0]    ack_b, dout_ok_b;
    logic [DW-1:0] dout_b, ram_din_b;
    logic          clr_busy_b, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_q_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtgng_ram_arb #(.DW(DW), .AW(AW), .CLR_EN(1'b1), .CLR_VAL(8'h00)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
        .ack(ack), .dout(dout), .dout_ok(dout_ok), .clr_busy(clr_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_q(ram_q)
    );

    jtgng_ram_arb #(.DW(DW), .AW(AW), .CLR_EN(1'b0), .CLR_VAL(8'h00)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(3'b000), .addr(addr), .din(din),
        .ack(ack_b), .dout(dout_b), .dout_ok(dout_ok_b), .clr_busy(clr_busy_b),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_din(ram_din_b),
        .ram_q(ram_q_b)
    );

    assign ram_q_b = 8'h00;

    // Behavioural RAM with a one-cycle registered read.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_q <= ram_mem[ram_addr];
        end
    end

    // Reference model: expected RAM contents, last winner and pending reads.
    typedef struct {
        int         due;
        logic [2:0] ok;
        logic [7:0] data;
    } rd_t;

    rd_t        pend[$];
    logic [7:0] mem_m [16];
    int         last;
    int         cyc;
    bit         en_pend, we_pend;
    logic [3:0] addr_pend;
    logic [7:0] din_pend;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [11:0] addr;
        logic [23:0] din;
        logic [2:0]  ack;
        logic [2:0]  ok;
        logic        en;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: scan upward starting just after the last winner.
    function automatic logic [2:0] pick(input logic [2:0] r, input int lst);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (lst + k) % 3;
            if (r[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    task automatic model_reset();
        last      = 2;
        cyc       = 0;
        en_pend   = 1'b0;
        we_pend   = 1'b0;
        addr_pend = 4'h0;
        din_pend  = 8'h00;
        pend.delete();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    endtask

    // Compare one cycle against the model at the falling edge and advance it.
    task automatic mcheck();
        logic [2:0] exp_ack, exp_ok;
        logic [7:0] exp_d;
        logic [3:0] a;
        int         w;
        @(negedge clk);
        exp_ack = pick(req, last);
        chk("ack", 32'(ack), 32'(exp_ack));
        exp_ok = 3'b000;
        exp_d  = 8'h00;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_ok = pend[0].ok;
            exp_d  = pend[0].data;
            void'(pend.pop_front());
        end
        chk("dout_ok", 32'(dout_ok), 32'(exp_ok));
        if (exp_ok != 3'b000) chk("dout", 32'(dout), 32'(exp_d));
        chk("ram_en", 32'(ram_en), 32'(en_pend));
        chk("ram_we", 32'(ram_we), 32'(en_pend & we_pend));
        chk("ram_addr", 32'(ram_addr), 32'(addr_pend));
        chk("ram_din", 32'(ram_din), 32'(din_pend));
        if (exp_ack != 3'b000) begin
            w    = exp_ack[0] ? 0 : (exp_ack[1] ? 1 : 2);
            last = w;
            a    = addr[w*AW +: AW];
            if (we[w]) mem_m[a] = din[w*DW +: DW];
            else       pend.push_back('{cyc + 2, exp_ack, mem_m[a]});
            en_pend   = 1'b1;
            we_pend   = we[w];
            addr_pend = a;
            din_pend  = din[w*DW +: DW];
        end else begin
            en_pend = 1'b0;
            we_pend = 1'b0;
        end
        cyc++;
    endtask

    // Check a full 16-address clear sweep starting in the current cycle.
    task automatic sweep_chk();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("clr_en", 32'(ram_en), 32'd1);
            chk("clr_we", 32'(ram_we), 32'd1);
            chk("clr_addr", 32'(ram_addr), 32'(i));
            chk("clr_din", 32'(ram_din), 32'h00);
            chk("clr_busy", 32'(clr_busy), 32'd1);
            chk("clr_ack", 32'(ack), 32'd0);
            chk("clr_dout_ok", 32'(dout_ok), 32'd0);
            if (i == 0) begin
                chk("b_first_ack", 32'(ack_b), 32'b100);
                chk("b_clr_busy", 32'(clr_busy_b), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        tbl[0]  = '{3'b001, 3'b001, 12'h533, 24'h0000A5, 3'b001, 3'b000, 1'b0, 8'h00};
        tbl[1]  = '{3'b010, 3'b000, 12'h533, 24'h0000A5, 3'b010, 3'b000, 1'b1, 8'h00};
        tbl[2]  = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b000, 1'b1, 8'h00};
        tbl[3]  = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b010, 1'b0, 8'hA5};
        tbl[4]  = '{3'b100, 3'b000, 12'h533, 24'h0000A5, 3'b100, 3'b000, 1'b0, 8'h00};
        tbl[5]  = '{3'b100, 3'b000, 12'h533, 24'h0000A5, 3'b100, 3'b000, 1'b1, 8'h00};
        tbl[6]  = '{3'b100, 3'b000, 12'h533, 24'h0000A5, 3'b100, 3'b100, 1'b1, 8'h00};
        tbl[7]  = '{3'b100, 3'b000, 12'h533, 24'h0000A5, 3'b100, 3'b100, 1'b1, 8'h00};
        tbl[8]  = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b100, 1'b1, 8'h00};
        tbl[9]  = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b100, 1'b0, 8'h00};
        tbl[10] = '{3'b011, 3'b000, 12'h533, 24'h0000A5, 3'b001, 3'b000, 1'b0, 8'h00};
        tbl[11] = '{3'b011, 3'b000, 12'h533, 24'h0000A5, 3'b010, 3'b000, 1'b1, 8'h00};
        tbl[12] = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b001, 1'b1, 8'hA5};
        tbl[13] = '{3'b000, 3'b000, 12'h533, 24'h0000A5, 3'b000, 3'b010, 1'b0, 8'hA5};

        rst   = 1'b1;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        din   = '0;
        req_b = 3'b000;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dout_ok", 32'(dout_ok), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd1);
        chk("rst_b_clr_busy", 32'(clr_busy_b), 32'd0);
        tick();

        // Release reset with every requester reading; the sweep must hold them off.
        rst   = 1'b0;
        req   = 3'b111;
        addr  = 12'h321;
        req_b = 3'b100;
        sweep_chk();

        // Rotation with all three reading; data comes from the cleared RAM.
        model_reset();
        for (int k = 0; k < 9; k++) begin
            mcheck();
            if (k == 0) chk("clr_busy_fall", 32'(clr_busy), 32'd0);
            chk("rr_ack", 32'(ack), 32'(1 << (k % 3)));
            tick();
        end
        req = 3'b000;
        repeat (2) begin
            mcheck();
            tick();
        end

        // Hand-derived sequences: write-then-read, held single requester, priority.
        for (int i = 0; i < 14; i++) begin
            req  = tbl[i].req;
            we   = tbl[i].we;
            addr = tbl[i].addr;
            din  = tbl[i].din;
            mcheck();
            chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_ok", i), 32'(dout_ok), 32'(tbl[i].ok));
            chk($sformatf("tbl%0d_en", i), 32'(ram_en), 32'(tbl[i].en));
            if (tbl[i].ok != 3'b000) chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
            tick();
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            req  = 3'($urandom);
            we   = 3'($urandom);
            addr = 12'($urandom);
            din  = 24'($urandom);
            mcheck();
            tick();
        end
        req = 3'b000;
        repeat (3) begin
            mcheck();
            tick();
        end

        // Reset while a read is in flight: no strobe, sweep restarts at 0.
        req  = 3'b001;
        we   = 3'b000;
        addr = 12'h007;
        mcheck();
        tick();
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_dout_ok", 32'(dout_ok), 32'd0);
        chk("abort_ram_en", 32'(ram_en), 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        chk("abort_clr_busy", 32'(clr_busy), 32'd1);
        tick();
        @(negedge clk);
        chk("abort_dout_ok2", 32'(dout_ok), 32'd0);
        tick();
        rst = 1'b0;
        sweep_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
